// File: rtl/spiral_plot_if.sv
// -----------------------------------------------------------------------------
// spiral_plot_if
//
// Purpose: bundles the sample input and pixel-write/status outputs of
// spiral_plot so the producer side (coordinate source / testbench) and the
// plotter connect through one port.
//
// Signals:
//   clear       producer -> plotter  synchronous restart
//   in_valid    producer -> plotter  x/y carry a sample this cycle
//   x, y        producer -> plotter  signed 32-bit coordinates
//   wr_en       plotter  -> producer pixel write strobe
//   wr_addr     plotter  -> producer pixel address (ADDR_W bits)
//   wr_data     plotter  -> producer pixel colour (sample index low byte)
//   in_count    plotter  -> producer accepted samples
//   clip_count  plotter  -> producer accepted samples outside the window
//   done        plotter  -> producer every window pixel has been written
//
// Modports: master = sample producer, slave = spiral_plot.
// -----------------------------------------------------------------------------
interface spiral_plot_if #(
    parameter int ADDR_W = 8
);
    logic                clear;
    logic                in_valid;
    logic signed [31:0]  x;
    logic signed [31:0]  y;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          wr_data;
    logic [31:0]         in_count;
    logic [31:0]         clip_count;
    logic                done;

    modport master (
        output clear, in_valid, x, y,
        input  wr_en, wr_addr, wr_data, in_count, clip_count, done
    );

    modport slave (
        input  clear, in_valid, x, y,
        output wr_en, wr_addr, wr_data, in_count, clip_count, done
    );
endinterface

// File: rtl/spiral_plot.sv
// -----------------------------------------------------------------------------
// spiral_plot
//
// Purpose: takes a stream of signed (x, y) points from the spiral generator,
// maps them into a WIDTH x HEIGHT window centred on the spiral origin, drops
// points outside the window and emits one pixel write per in-window point
// (colour = sample index). Raises done once WIDTH*HEIGHT writes were issued.
//
// Ports:
//   clk    in   clock, all state on rising edge
//   reset  in   asynchronous active-high reset
//   bus    slave modport of spiral_plot_if (clear, in_valid, x, y in;
//               wr_en, wr_addr, wr_data, in_count, clip_count, done out)
//
// Pipeline (one sample per cycle, no backpressure):
//   capture : register x, y and the sample index, bump in_count
//   stage 1 : offset into window, in-window test, clip_count for misses
//   stage 2 : pixel write (wr_en / wr_addr / wr_data), counted by written
// -----------------------------------------------------------------------------
module spiral_plot #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    spiral_plot_if.slave  bus
);
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int OX    = (WIDTH - 1) / 2;
    localparam int OY    = (HEIGHT - 1) / 2;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t state_q, state_d;

    // capture register
    logic               cap_valid_q;
    logic signed [31:0] cap_x_q;
    logic signed [31:0] cap_y_q;
    logic [7:0]         cap_color_q;

    // stage 1 (only in-window samples are marked valid here)
    logic               s1_valid_q;
    logic [ADDR_W-1:0]  s1_xo_q;
    logic [ADDR_W-1:0]  s1_yo_q;
    logic [7:0]         s1_color_q;

    // stage 2 / outputs
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [7:0]         wr_data_q;
    logic [31:0]        in_count_q;
    logic [31:0]        clip_count_q;
    logic [31:0]        written_q;

    logic signed [32:0] xo_w;
    logic signed [32:0] yo_w;
    logic               in_win_w;
    logic [ADDR_W-1:0]  addr_w;
    logic               go_done_w;

    // Offsets are formed at 33 bits so coordinates near +/-2^31 cannot wrap
    // around into the window.
    assign xo_w = {cap_x_q[31], cap_x_q} + 33'(OX);
    assign yo_w = {cap_y_q[31], cap_y_q} + 33'(OY);

    // Sign bit clear means xo/yo >= 0, so the low 32 bits compare unsigned.
    assign in_win_w = !xo_w[32] && (xo_w[31:0] < 32'(WIDTH)) &&
                      !yo_w[32] && (yo_w[31:0] < 32'(HEIGHT));

    assign addr_w = ADDR_W'(32'(s1_yo_q) * 32'(WIDTH) + 32'(s1_xo_q));

    // Next-state logic. The final write is the one on wr_en while written
    // already counts TOTAL-1 pixels; the machine parks in DONE on that edge.
    always_comb begin
        state_d   = state_q;
        go_done_w = 1'b0;
        if (bus.clear) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN && wr_en_q &&
                     written_q == 32'(TOTAL - 1)) begin
            go_done_w = 1'b1;
            state_d   = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_valid_q  <= 1'b0;
            cap_x_q      <= '0;
            cap_y_q      <= '0;
            cap_color_q  <= '0;
            s1_valid_q   <= 1'b0;
            s1_xo_q      <= '0;
            s1_yo_q      <= '0;
            s1_color_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            in_count_q   <= '0;
            clip_count_q <= '0;
            written_q    <= '0;
        end else if (bus.clear) begin
            // Restart: flush all stages and counters; a sample offered in
            // the same cycle is discarded. wr_addr/wr_data keep their value.
            cap_valid_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            in_count_q   <= '0;
            clip_count_q <= '0;
            written_q    <= '0;
        end else if (state_q == S_RUN) begin
            cap_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                cap_x_q     <= bus.x;
                cap_y_q     <= bus.y;
                cap_color_q <= in_count_q[7:0];
                in_count_q  <= in_count_q + 32'd1;
            end

            s1_valid_q <= cap_valid_q && in_win_w;
            if (cap_valid_q && in_win_w) begin
                s1_xo_q    <= xo_w[ADDR_W-1:0];
                s1_yo_q    <= yo_w[ADDR_W-1:0];
                s1_color_q <= cap_color_q;
            end
            if (cap_valid_q && !in_win_w) begin
                clip_count_q <= clip_count_q + 32'd1;
            end

            // No new write may appear in the first DONE cycle.
            wr_en_q <= s1_valid_q && !go_done_w;
            if (s1_valid_q && !go_done_w) begin
                wr_addr_q <= addr_w;
                wr_data_q <= s1_color_q;
            end

            if (wr_en_q) begin
                written_q <= written_q + 32'd1;
            end
        end else begin
            // DONE: anything still in flight is dropped, counters frozen.
            cap_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            wr_en_q     <= 1'b0;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.in_count   = in_count_q;
    assign bus.clip_count = clip_count_q;
    assign bus.done       = (state_q == S_DONE);
endmodule
